div_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the single shared sequential divider in the bike computer. Measurement blocks (current speed, average speed, cadence) each present a dividend/divisor pair. The arbiter grants one requester at a time, issues the divider start pulse, tracks the busy/ready handshake, and returns the quotient with a per-requester done pulse. It sits between the measurement blocks and the divider, so no requester drives the divider directly.

---
 rtl/div_arbiter.sv | 130 +++++++++++++
 tb/tb_div_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter that sequences requesters onto one shared divider
module div_arbiter #(
  parameter int WIDTH   = 16,
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_dividend,
  input  logic [N_REQ*WIDTH-1:0] req_divisor,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   err,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  input  logic                   div_busy,
  input  logic                   div_ready,
  input  logic [WIDTH-1:0]       div_result
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_READY, DONE} state_t;
  state_t           r_state, w_state;
  logic [N_REQ-1:0] r_gnt, w_gnt, r_done, w_done, w_oh;
  logic [WIDTH-1:0] r_result, w_result, r_dvd, w_dvd, r_dvs, w_dvs, w_lane_dvd, w_lane_dvs;
  logic             r_err, w_err, r_start, w_start;
  logic [IW-1:0]    r_last, w_last, w_win;
  logic [TW-1:0]    r_timer, w_timer;
  assign gnt          = r_gnt;
  assign done         = r_done;
  assign result       = r_result;
  assign err          = r_err;
  assign div_start    = r_start;
  assign div_dividend = r_dvd;
  assign div_divisor  = r_dvs;
  assign w_oh         = N_REQ'(1) << w_win;
  // Descending scan so the lowest offset after r_last is the final (winning) assignment.
  always_comb begin
    w_win = r_last;
    for (int i = N_REQ; i >= 1; i--)
      if (req[IW'((int'(r_last) + i) % N_REQ)]) w_win = IW'((int'(r_last) + i) % N_REQ);
  end
  always_comb begin
    w_lane_dvd = '0;
    w_lane_dvs = '0;
    for (int i = 0; i < N_REQ; i++)
      if (IW'(i) == w_win) begin
        w_lane_dvd = req_dividend[i*WIDTH +: WIDTH];
        w_lane_dvs = req_divisor[i*WIDTH +: WIDTH];
      end
  end
  always_comb begin
    w_state  = r_state;
    w_gnt    = r_gnt;
    w_done   = '0;
    w_result = r_result;
    w_err    = r_err;
    w_start  = 1'b0;
    w_dvd    = r_dvd;
    w_dvs    = r_dvs;
    w_last   = r_last;
    w_timer  = r_timer;
    case (r_state)
      IDLE: if (|req) begin
        w_gnt   = w_oh;
        w_last  = w_win;
        w_dvd   = w_lane_dvd;
        w_dvs   = w_lane_dvs;
        w_timer = '0;
        if (|w_lane_dvs) begin
          w_start = 1'b1;
          w_state = WAIT_BUSY;
        end else begin
          w_result = '1;
          w_err    = 1'b1;
          w_done   = w_oh;
          w_state  = DONE;
        end
      end
      WAIT_BUSY, WAIT_READY: begin
        w_timer = r_timer + TW'(1);
        if (div_ready) begin
          w_result = div_result;
          w_err    = 1'b0;
          w_done   = r_gnt;
          w_state  = DONE;
        end else if (r_timer == TW'(TIMEOUT)) begin
          w_result = '0;
          w_err    = 1'b1;
          w_done   = r_gnt;
          w_state  = DONE;
        end else if (r_state == WAIT_BUSY && div_busy) begin
          w_state = WAIT_READY;
        end
      end
      default: begin
        w_gnt   = '0;
        w_state = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_start  <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_last   <= IW'(N_REQ - 1);
      r_timer  <= '0;
    end else begin
      r_state  <= w_state;
      r_gnt    <= w_gnt;
      r_done   <= w_done;
      r_result <= w_result;
      r_err    <= w_err;
      r_start  <= w_start;
      r_dvd    <= w_dvd;
      r_dvs    <= w_dvs;
      r_last   <= w_last;
      r_timer  <= w_timer;
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed scenarios against div_arbiter with a scripted divider model
module tb_div_arbiter;
  localparam int W = 16;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] dvd = '0, dvs = '0;
  logic [N-1:0] gnt, done;
  logic [W-1:0] result, div_dividend, div_divisor;
  logic err, div_start;
  logic div_busy = 1'b0, div_ready = 1'b0;
  logic [W-1:0] div_result = '0;
  int n_cmp = 0, n_bad = 0;
  logic dv_en = 1'b1, busy_en = 1'b1, force_rdy = 1'b0;
  int lat = 1, dcnt = -1;
  logic [W-1:0] q = '0;
  always #5 clk = ~clk;
  div_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dividend(dvd), .req_divisor(dvs),
    .gnt(gnt), .done(done), .result(result), .err(err), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_ready(div_ready), .div_result(div_result)
  );
  // Divider model: ready pulses lat cycles after the cycle div_start is seen.
  always @(negedge clk) begin
    div_ready = force_rdy;
    if (dcnt == 0) begin
      div_ready = 1'b1;
      div_result = q;
      div_busy = 1'b0;
      dcnt = -1;
    end else if (dcnt > 0) dcnt--;
    if (div_start && dv_en) begin
      div_busy = busy_en;
      dcnt = lat - 1;
      q = div_dividend / div_divisor;
    end
  end
  task automatic wait_done(input int lim, output int n, output int starts);
    n = 0;
    starts = 0;
    do begin
      @(negedge clk);
      n++;
      starts += int'(div_start);
    end while (done == '0 && n < lim);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL rst_gnt got=%b exp=000", gnt); end
    n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL rst_done got=%b exp=000", done); end
    n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL rst_result got=%h exp=0000", result); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL rst_start got=%b exp=0", div_start); end
    n_cmp++; if (div_dividend !== 16'h0000) begin n_bad++; $display("FAIL rst_dvd got=%h exp=0000", div_dividend); end
    n_cmp++; if (div_divisor !== 16'h0000) begin n_bad++; $display("FAIL rst_dvs got=%h exp=0000", div_divisor); end
    rst = 1'b0;
  endtask
  task automatic test_single;
    int n, s;
    busy_en = 1'b1; lat = 16; dv_en = 1'b1;
    dvd[0 +: W] = 16'd7373; dvs[0 +: W] = 16'd100; req = 3'b001;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL single_gnt got=%b exp=001", gnt); end
    n_cmp++; if (div_start !== 1'b1) begin n_bad++; $display("FAIL single_start got=%b exp=1", div_start); end
    wait_done(40, n, s);
    n_cmp++; if (n != 17) begin n_bad++; $display("FAIL single_latency got=%0d exp=17", n); end
    n_cmp++; if (s != 0) begin n_bad++; $display("FAIL single_extra_starts got=%0d exp=0", s); end
    n_cmp++; if (done !== 3'b001) begin n_bad++; $display("FAIL single_done got=%b exp=001", done); end
    n_cmp++; if (result !== 16'd73) begin n_bad++; $display("FAIL single_result got=%0d exp=73", result); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got=%b exp=0", err); end
    n_cmp++; if (div_dividend !== 16'd7373) begin n_bad++; $display("FAIL single_dvd_stable got=%0d exp=7373", div_dividend); end
    req = 3'b000;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL single_gnt_drop got=%b exp=000", gnt); end
    n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL single_done_pulse got=%b exp=000", done); end
  endtask
  task automatic test_round_robin;
    logic [N-1:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [N-1:0] pg = '0;
    logic [W-1:0] eq;
    int ng = 0, nd = 0, n = 0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    busy_en = 1'b1; lat = 1;
    dvd = {16'd100, 16'd100, 16'd100}; dvs = {16'd4, 16'd5, 16'd10};
    req = 3'b111;
    while (nd < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (gnt != '0 && pg == '0) begin
        if (ng < 6) begin
          n_cmp++; if (gnt !== exp_g[ng]) begin n_bad++; $display("FAIL rr_order[%0d] got=%b exp=%b", ng, gnt, exp_g[ng]); end
        end
        ng++;
        if (ng == 6) req = 3'b000;
      end
      if (done != '0) begin
        eq = (done == 3'b001) ? 16'd10 : (done == 3'b010) ? 16'd20 : 16'd25;
        n_cmp++; if (result !== eq) begin n_bad++; $display("FAIL rr_result done=%b got=%0d exp=%0d", done, result, eq); end
        nd++;
      end
      pg = gnt;
    end
    n_cmp++; if (nd != 6) begin n_bad++; $display("FAIL rr_done_count got=%0d exp=6", nd); end
    @(negedge clk);
  endtask
  task automatic test_div_zero;
    dvd[W +: W] = 16'd5; dvs[W +: W] = 16'd0; req = 3'b010;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL dz_gnt got=%b exp=010", gnt); end
    n_cmp++; if (done !== 3'b010) begin n_bad++; $display("FAIL dz_done got=%b exp=010", done); end
    n_cmp++; if (result !== 16'hFFFF) begin n_bad++; $display("FAIL dz_result got=%h exp=ffff", result); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL dz_err got=%b exp=1", err); end
    n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL dz_start got=%b exp=0", div_start); end
    req = 3'b000;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL dz_gnt_drop got=%b exp=000", gnt); end
    n_cmp++; if (result !== 16'hFFFF) begin n_bad++; $display("FAIL dz_result_held got=%h exp=ffff", result); end
  endtask
  task automatic test_timeout;
    int n, s;
    dv_en = 1'b0;
    dvd[2*W +: W] = 16'd1; dvs[2*W +: W] = 16'd1; req = 3'b100;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b100) begin n_bad++; $display("FAIL to_gnt got=%b exp=100", gnt); end
    wait_done(40, n, s);
    n_cmp++; if (n != 21) begin n_bad++; $display("FAIL to_latency got=%0d exp=21", n); end
    n_cmp++; if (done !== 3'b100) begin n_bad++; $display("FAIL to_done got=%b exp=100", done); end
    n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL to_result got=%h exp=0000", result); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err got=%b exp=1", err); end
    req = 3'b000;
    @(negedge clk);
    dv_en = 1'b1; busy_en = 1'b1; lat = 3;
    dvd[0 +: W] = 16'd50; dvs[0 +: W] = 16'd7; req = 3'b001;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL to_next_gnt got=%b exp=001", gnt); end
    wait_done(40, n, s);
    n_cmp++; if (n != 4) begin n_bad++; $display("FAIL to_next_latency got=%0d exp=4", n); end
    n_cmp++; if (result !== 16'd7) begin n_bad++; $display("FAIL to_next_result got=%0d exp=7", result); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_next_err got=%b exp=0", err); end
    req = 3'b000;
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int n, s, seen = 0;
    busy_en = 1'b1; lat = 10;
    dvd[W +: W] = 16'd900; dvs[W +: W] = 16'd9; req = 3'b010;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL rm_gnt got=%b exp=010", gnt); end
    req = 3'b000;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL rm_gnt_rst got=%b exp=000", gnt); end
    n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL rm_result_rst got=%h exp=0000", result); end
    n_cmp++; if (div_dividend !== 16'h0000) begin n_bad++; $display("FAIL rm_dvd_rst got=%h exp=0000", div_dividend); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rm_err_rst got=%b exp=0", err); end
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rm_stale_done got=%0d exp=0", seen); end
    n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL rm_stale_result got=%h exp=0000", result); end
    lat = 2;
    dvd[0 +: W] = 16'd30; dvs[0 +: W] = 16'd3;
    dvd[2*W +: W] = 16'd1000; dvs[2*W +: W] = 16'd8;
    req = 3'b101;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL rm_tie_gnt got=%b exp=001", gnt); end
    wait_done(40, n, s);
    n_cmp++; if (result !== 16'd10) begin n_bad++; $display("FAIL rm_tie_result got=%0d exp=10", result); end
    repeat (2) @(negedge clk);
    n_cmp++; if (gnt !== 3'b100) begin n_bad++; $display("FAIL rm_next_gnt got=%b exp=100", gnt); end
    req = 3'b000;
    wait_done(40, n, s);
    n_cmp++; if (done !== 3'b100) begin n_bad++; $display("FAIL rm_next_done got=%b exp=100", done); end
    n_cmp++; if (result !== 16'd125) begin n_bad++; $display("FAIL rm_next_result got=%0d exp=125", result); end
    @(negedge clk);
  endtask
  task automatic test_fast;
    int n, s, seen = 0;
    busy_en = 1'b0; lat = 2;
    force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL fast_stray_done got=%0d exp=0", seen); end
    dvd[0 +: W] = 16'd81; dvs[0 +: W] = 16'd9; req = 3'b001;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL fast_gnt got=%b exp=001", gnt); end
    wait_done(40, n, s);
    n_cmp++; if (n != 3) begin n_bad++; $display("FAIL fast_latency got=%0d exp=3", n); end
    n_cmp++; if (done !== 3'b001) begin n_bad++; $display("FAIL fast_done got=%b exp=001", done); end
    n_cmp++; if (result !== 16'd9) begin n_bad++; $display("FAIL fast_result got=%0d exp=9", result); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fast_err got=%b exp=0", err); end
    req = 3'b000;
    @(negedge clk);
    n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL fast_gnt_drop got=%b exp=000", gnt); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_div_zero;
    test_timeout;
    test_reset_mid;
    test_fast;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
